// File: rtl/usbh_nes_pad_responder_if.sv
// NES controller-port signals between the console (master) and the pad emulator (slave).
interface usbh_nes_pad_responder_if;
  logic       i_latch;
  logic       i_pclk;
  logic       o_data;
  logic [3:0] o_reads;

  modport master (
    output i_latch,
    output i_pclk,
    input  o_data,
    input  o_reads
  );

  modport slave (
    input  i_latch,
    input  i_pclk,
    output o_data,
    output o_reads
  );
endinterface

// File: rtl/usbh_nes_pad_responder.sv
// 4021-style NES pad emulator: conditions the console latch/clock pins and serialises the
// USB-decoded button byte back to the console.
module usbh_nes_pad_responder #(
  parameter int unsigned c_sync_stages   = 2,
  parameter int unsigned c_filter_cycles = 3,
  parameter bit          c_active_low    = 1'b1
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [7:0]                      i_btn,
  usbh_nes_pad_responder_if.slave         pad
);

  localparam int unsigned CntW = (c_filter_cycles < 2) ? 1 : $clog2(c_filter_cycles);
  localparam logic [CntW-1:0] CntMax = CntW'(c_filter_cycles - 1);
  // Pin index 0 = latch (idles low), 1 = pclk (idles high).
  localparam logic [1:0] IdleLvl = 2'b10;

  typedef enum logic [1:0] {StLoad, StShift, StDone} state_e;

  logic [1:0][c_sync_stages-1:0] sync_q;
  logic [1:0]                    pin_raw, pin_sync;
  logic [1:0]                    filt_q, filt_d;
  logic [1:0][CntW-1:0]          cnt_q, cnt_d;
  logic                          pclk_prev_q;
  logic                          pclk_rise;

  state_e     state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [3:0] reads_q, reads_d;
  logic       data_q;

  assign pin_raw = {pad.i_pclk, pad.i_latch};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      pin_sync[i] = sync_q[i][c_sync_stages-1];
    end
  end

  // A differing sample must persist c_filter_cycles cycles; any matching sample restarts it.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    for (int i = 0; i < 2; i++) begin
      if (pin_sync[i] != filt_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          filt_d[i] = pin_sync[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= {c_sync_stages{IdleLvl[i]}};
      end
      filt_q      <= IdleLvl;
      cnt_q       <= '0;
      pclk_prev_q <= IdleLvl[1];
    end else begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= {sync_q[i][c_sync_stages-2:0], pin_raw[i]};
      end
      filt_q      <= filt_d;
      cnt_q       <= cnt_d;
      pclk_prev_q <= filt_q[1];
    end
  end

  assign pclk_rise = filt_q[1] & ~pclk_prev_q;

  // Latch level dominates: it reloads every cycle and masks a coincident pclk edge.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    reads_d = reads_q;
    if (filt_q[0]) begin
      state_d = StLoad;
      sr_d    = i_btn;
      reads_d = 4'd0;
    end else begin
      unique case (state_q)
        StLoad: state_d = StShift;
        StShift: begin
          if (pclk_rise) begin
            sr_d    = {1'b1, sr_q[7:1]};
            reads_d = reads_q + 4'd1;
            if (reads_q == 4'd7) begin
              state_d = StDone;
            end
          end
        end
        StDone: begin
          if (pclk_rise) begin
            sr_d = {1'b1, sr_q[7:1]};
          end
        end
        default: state_d = StShift;
      endcase
    end
  end

  // Reset lands in StShift with sr cleared, so the pin reads logical 0 until a latch.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StShift;
      sr_q    <= 8'h00;
      reads_q <= 4'd0;
      data_q  <= c_active_low;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      reads_q <= reads_d;
      data_q  <= sr_d[0] ^ c_active_low;
    end
  end

  assign pad.o_data  = data_q;
  assign pad.o_reads = reads_q;

endmodule

// File: tb/tb_usbh_nes_pad_responder.sv
// Directed bench for the NES pad responder with default parameters (active-low pin).
module tb_usbh_nes_pad_responder;

  logic       clk;
  logic       rst_n;
  logic [7:0] btn;
  int         n_checks;
  int         n_pass;

  usbh_nes_pad_responder_if pad_if ();

  usbh_nes_pad_responder dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_btn   (btn),
    .pad     (pad_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic latch_pulse();
    pad_if.i_latch = 1'b1;
    tick(12);
    pad_if.i_latch = 1'b0;
    tick(10);
  endtask

  task automatic pclk_pulse();
    pad_if.i_pclk = 1'b0;
    tick(8);
    pad_if.i_pclk = 1'b1;
    tick(8);
  endtask

  // Checks the pin (active low) before each rising edge against the logical bit sequence.
  task automatic read_seq(input string tag, input logic [7:0] logical_bits, input int start);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s bit%0d", tag, i), {31'd0, pad_if.o_data}, {31'd0, ~logical_bits[i]});
      check($sformatf("%s reads%0d", tag, i), {28'd0, pad_if.o_reads}, start + i);
      pclk_pulse();
    end
  endtask

  initial begin
    n_checks       = 0;
    n_pass         = 0;
    rst_n          = 1'b0;
    btn            = 8'h00;
    pad_if.i_latch = 1'b0;
    pad_if.i_pclk  = 1'b1;
    tick(3);
    check("reset data pin", {31'd0, pad_if.o_data}, 32'd1);
    check("reset reads", {28'd0, pad_if.o_reads}, 32'd0);
    rst_n = 1'b1;
    tick(5);

    // Basic read: A, Sel, Right pressed.
    btn = 8'b1000_0101;
    latch_pulse();
    read_seq("basic", 8'b1000_0101, 0);
    check("basic reads after 8", {28'd0, pad_if.o_reads}, 32'd8);

    // Over-read returns logical 1 and reads stays saturated.
    for (int i = 0; i < 4; i++) begin
      check($sformatf("over data%0d", i), {31'd0, pad_if.o_data}, 32'd0);
      pclk_pulse();
      check($sformatf("over reads%0d", i), {28'd0, pad_if.o_reads}, 32'd8);
    end

    // Button change after latch falls is not seen.
    btn = 8'h01;
    latch_pulse();
    btn = 8'hFE;
    read_seq("midchg", 8'h01, 0);

    // Transparent latch: output follows btn[0] one cycle later, pclk ignored.
    btn = 8'h00;
    pad_if.i_latch = 1'b1;
    tick(10);
    check("xparent idle", {31'd0, pad_if.o_data}, 32'd1);
    btn[0] = 1'b1;
    tick(1);
    check("xparent set", {31'd0, pad_if.o_data}, 32'd0);
    btn[0] = 1'b0;
    tick(1);
    check("xparent clr", {31'd0, pad_if.o_data}, 32'd1);
    pclk_pulse();
    pclk_pulse();
    check("xparent reads", {28'd0, pad_if.o_reads}, 32'd0);
    pad_if.i_latch = 1'b0;
    tick(10);
    check("xparent after fall", {28'd0, pad_if.o_reads}, 32'd0);

    // Glitch rejection: 2-cycle low ignored, 3-cycle low accepted.
    pad_if.i_pclk = 1'b0;
    tick(2);
    pad_if.i_pclk = 1'b1;
    tick(10);
    check("glitch 2cyc reads", {28'd0, pad_if.o_reads}, 32'd0);
    pad_if.i_pclk = 1'b0;
    tick(3);
    pad_if.i_pclk = 1'b1;
    tick(10);
    check("glitch 3cyc reads", {28'd0, pad_if.o_reads}, 32'd1);
    check("glitch 3cyc data", {31'd0, pad_if.o_data}, 32'd1);

    // Reset mid-read after three shifts.
    btn = 8'h0F;
    latch_pulse();
    for (int i = 0; i < 3; i++) pclk_pulse();
    check("pre-reset reads", {28'd0, pad_if.o_reads}, 32'd3);
    check("pre-reset data", {31'd0, pad_if.o_data}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("async reset data", {31'd0, pad_if.o_data}, 32'd1);
    check("async reset reads", {28'd0, pad_if.o_reads}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(10);
    check("post-reset reads", {28'd0, pad_if.o_reads}, 32'd0);
    check("post-reset data", {31'd0, pad_if.o_data}, 32'd1);
    btn = 8'hA6;
    latch_pulse();
    read_seq("fresh", 8'hA6, 0);
    check("fresh reads end", {28'd0, pad_if.o_reads}, 32'd8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
